// File: rtl/mult_sched.sv
// Round-robin scheduler for a shared pipelined multiplier: credit-gated issue, a tag pipeline
// that mirrors the multiplier latency, and a result FIFO draining toward the CDB.
module mult_sched #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned STAGES = 4,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned TAGW   = 5,
  localparam int unsigned SelW  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW  = $clog2(DEPTH + 1),
  localparam int unsigned IfW   = $clog2(STAGES + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*TAGW-1:0]  req_tag,
  output logic [N_REQ-1:0]       req_grant,
  output logic                   mult_start,
  output logic [SelW-1:0]        mult_sel,
  input  logic                   mult_done,
  input  logic [XLEN-1:0]        mult_result,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [XLEN-1:0]        out_result,
  output logic [TAGW-1:0]        out_tag,
  output logic [SelW-1:0]        out_req,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   err
);

  logic [SelW-1:0]   rr_q, rr_d;
  logic [STAGES-1:0] pipe_vld_q, pipe_vld_d;
  logic [TAGW-1:0]   pipe_tag_q [STAGES];
  logic [TAGW-1:0]   pipe_tag_d [STAGES];
  logic [SelW-1:0]   pipe_req_q [STAGES];
  logic [SelW-1:0]   pipe_req_d [STAGES];
  logic [XLEN-1:0]   fifo_res_q [DEPTH];
  logic [TAGW-1:0]   fifo_tag_q [DEPTH];
  logic [SelW-1:0]   fifo_req_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic              err_q, err_d;

  logic [IfW-1:0]    inflight_cnt;
  logic              credit_ok, found;
  logic [TAGW-1:0]   grant_tag;
  logic              tail_vld, push, pop, fifo_full, push_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // Credits cover every op from issue until its result leaves the FIFO.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < STAGES; i++) begin
      inflight_cnt = inflight_cnt + IfW'(pipe_vld_q[i]);
    end
    credit_ok = (32'(inflight_cnt) + 32'(fifo_cnt_q)) < DEPTH;
  end

  always_comb begin
    req_grant = '0;
    mult_sel  = '0;
    found     = 1'b0;
    if (reset && !flush && credit_ok) begin
      for (int unsigned k = 1; k <= N_REQ; k++) begin
        if (!found && req_valid[(32'(rr_q) + k) % N_REQ]) begin
          found = 1'b1;
          req_grant[(32'(rr_q) + k) % N_REQ] = 1'b1;
          mult_sel = SelW'((32'(rr_q) + k) % N_REQ);
        end
      end
    end
    mult_start = found;
    grant_tag  = req_tag[32'(mult_sel) * TAGW +: TAGW];
    rr_d       = found ? mult_sel : rr_q;
  end

  always_comb begin
    pipe_vld_d[0] = mult_start;
    pipe_tag_d[0] = grant_tag;
    pipe_req_d[0] = mult_sel;
    for (int i = 1; i < STAGES; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_tag_d[i] = pipe_tag_q[i-1];
      pipe_req_d[i] = pipe_req_q[i-1];
    end
    if (flush) pipe_vld_d = '0;
  end

  always_comb begin
    tail_vld   = pipe_vld_q[STAGES-1];
    out_valid  = fifo_cnt_q != '0;
    push       = tail_vld & mult_done & ~flush;
    pop        = out_valid & out_ready;
    fifo_full  = fifo_cnt_q == CntW'(DEPTH);
    push_ok    = push & (~fifo_full | pop);
    wr_ptr_d   = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    unique case ({push_ok, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
    end
    // A tail without done means the multiplier lost an op; a full push means credits broke.
    err_d = err_q | (tail_vld & ~mult_done) | (push & fifo_full & ~pop);
  end

  always_comb begin
    out_result = out_valid ? fifo_res_q[rd_ptr_q] : '0;
    out_tag    = out_valid ? fifo_tag_q[rd_ptr_q] : '0;
    out_req    = out_valid ? fifo_req_q[rd_ptr_q] : '0;
    busy       = (|pipe_vld_q) | out_valid;
    err        = err_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_q       <= SelW'(N_REQ - 1);
      pipe_vld_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        pipe_tag_q[i] <= '0;
        pipe_req_q[i] <= '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        fifo_res_q[i] <= '0;
        fifo_tag_q[i] <= '0;
        fifo_req_q[i] <= '0;
      end
    end else begin
      rr_q       <= rr_d;
      pipe_vld_q <= pipe_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      err_q      <= err_d;
      for (int i = 0; i < STAGES; i++) begin
        pipe_tag_q[i] <= pipe_tag_d[i];
        pipe_req_q[i] <= pipe_req_d[i];
      end
      if (push_ok) begin
        fifo_res_q[wr_ptr_q] <= mult_result;
        fifo_tag_q[wr_ptr_q] <= pipe_tag_q[STAGES-1];
        fifo_req_q[wr_ptr_q] <= pipe_req_q[STAGES-1];
      end
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
// Randomized bench for mult_sched: the bench plays the multiplier, models credits and
// round-robin order with queues, and a monitor scores every result leaving the FIFO.
module tb_mult_sched;
  localparam int N  = 4;
  localparam int ST = 4;
  localparam int D  = 4;
  localparam int X  = 32;
  localparam int T  = 5;
  localparam int SW = 2;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*T-1:0] req_tag = '0;
  logic [N-1:0]   req_grant;
  logic           mult_start;
  logic [SW-1:0]  mult_sel;
  logic           mult_done = 1'b0;
  logic [X-1:0]   mult_result = '0;
  logic           flush = 1'b0;
  logic           out_valid;
  logic [X-1:0]   out_result;
  logic [T-1:0]   out_tag;
  logic [SW-1:0]  out_req;
  logic           out_ready = 1'b0;
  logic           busy;
  logic           err;

  mult_sched #(.N_REQ(N), .STAGES(ST), .DEPTH(D), .XLEN(X), .TAGW(T)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_tag(req_tag),
    .req_grant(req_grant), .mult_start(mult_start), .mult_sel(mult_sel),
    .mult_done(mult_done), .mult_result(mult_result), .flush(flush),
    .out_valid(out_valid), .out_result(out_result), .out_tag(out_tag), .out_req(out_req),
    .out_ready(out_ready), .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct { logic [T-1:0] tag; int req; logic [X-1:0] res; int done; } rec_t;
  typedef struct { int cyc; logic [X-1:0] res; } mop_t;
  rec_t sb_q[$];
  mop_t mq[$];

  int n_chk = 0, n_pass = 0;
  int cyc = 0, rr_m = N - 1, grant_cnt = 0;
  bit [N-1:0] pend = '0;
  logic [T-1:0] ptag [N];
  bit rdy_v = 1'b0, flush_v = 1'b0, drop_done = 1'b0, err_exp = 1'b0, in_reset = 1'b1;
  bit res_ovr_en = 1'b0;
  logic [X-1:0] res_ovr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // One clock of stimulus: drive at negedge, check combinational grant, update model late.
  task automatic run_cycle();
    logic [N*T-1:0] tv;
    logic [N-1:0] exp_g;
    int exp_idx;
    bit found;
    logic [X-1:0] r;
    @(negedge clock);
    for (int i = 0; i < N; i++) tv[i*T +: T] = ptag[i];
    req_valid   = pend;
    req_tag     = tv;
    out_ready   = rdy_v;
    flush       = flush_v;
    mult_done   = 1'b0;
    mult_result = $urandom;
    if (mq.size() > 0 && mq[0].cyc == cyc) begin
      if (!drop_done) begin
        mult_done   = 1'b1;
        mult_result = mq[0].res;
      end
      void'(mq.pop_front());
    end
    #2;
    exp_g = '0; exp_idx = 0; found = 1'b0;
    if (!flush_v && sb_q.size() < D) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (rr_m + k) % N;
        if (!found && pend[j]) begin
          found = 1'b1; exp_idx = j; exp_g[j] = 1'b1;
        end
      end
    end
    chk("req_grant", 64'(req_grant), 64'(exp_g));
    chk("mult_start", 64'(mult_start), 64'(found));
    if (found) chk("mult_sel", 64'(mult_sel), 64'(exp_idx));
    chk("busy", 64'(busy), 64'(sb_q.size() != 0));
    chk("err", 64'(err), 64'(err_exp));
    #2;
    if (drop_done && sb_q.size() > 0 && sb_q[0].done == cyc) begin
      void'(sb_q.pop_front());
      err_exp = 1'b1;
    end
    if (flush_v) sb_q.delete();
    if (found) begin
      r = res_ovr_en ? res_ovr : X'($urandom);
      res_ovr_en = 1'b0;
      sb_q.push_back('{tag: ptag[exp_idx], req: exp_idx, res: r, done: cyc + ST});
      mq.push_back('{cyc: cyc + ST, res: r});
      pend[exp_idx] = 1'b0;
      rr_m = exp_idx;
      grant_cnt++;
    end
    cyc++;
  endtask

  // Monitor: scores the FIFO head against the oldest expected completion.
  initial begin
    forever begin
      @(negedge clock);
      #3;
      if (!in_reset) begin
        bit exp_v;
        exp_v = sb_q.size() > 0 && sb_q[0].done < cyc;
        chk("out_valid", 64'(out_valid), 64'(exp_v));
        if (exp_v && out_ready) begin
          chk("out_result", 64'(out_result), 64'(sb_q[0].res));
          chk("out_tag", 64'(out_tag), 64'(sb_q[0].tag));
          chk("out_req", 64'(out_req), 64'(sb_q[0].req));
          void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic drain();
    pend = '0; rdy_v = 1'b1; flush_v = 1'b0;
    for (int k = 0; k < 60 && sb_q.size() != 0; k++) run_cycle();
    run_cycle();
    chk("drain_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) ptag[i] = '0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(negedge clock);
    reset = 1'b1; in_reset = 1'b0;

    // Single op with a fixed tag and result.
    ptag[0] = 7; pend = 4'b0001; res_ovr_en = 1'b1; res_ovr = 32'h0000_0015; rdy_v = 1'b1;
    run_cycle();
    repeat (7) run_cycle();

    // Round-robin with all requesters held.
    pend = '1;
    for (int i = 0; i < N; i++) ptag[i] = T'($urandom);
    for (int k = 0; k < 30 && pend != '0; k++) run_cycle();
    drain();

    // Random traffic with backpressure and occasional flushes.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(9) < 4) begin
          pend[i] = 1'b1; ptag[i] = T'($urandom);
        end
      end
      rdy_v   = $urandom_range(9) < 7;
      flush_v = $urandom_range(99) < 3;
      run_cycle();
    end
    drain();

    // Backpressure: requester 2 always requesting, CDB stalled.
    rdy_v = 1'b0; grant_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (!pend[2]) begin pend[2] = 1'b1; ptag[2] = T'($urandom); end
      run_cycle();
    end
    chk("bp_grants", 64'(grant_cnt), 64'(D));
    rdy_v = 1'b1;
    if (!pend[2]) begin pend[2] = 1'b1; ptag[2] = T'($urandom); end
    run_cycle();
    rdy_v = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (!pend[2]) begin pend[2] = 1'b1; ptag[2] = T'($urandom); end
      run_cycle();
    end

    // Asynchronous reset mid-cycle with the FIFO full and a request still driven.
    @(negedge clock);
    #1;
    chk("pre_rst_full", 64'(out_valid), 64'd1);
    reset = 1'b0; in_reset = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_grant", 64'(req_grant), 64'd0);
    chk("arst_start", 64'(mult_start), 64'd0);
    chk("arst_result", 64'(out_result), 64'd0);
    chk("arst_tag", 64'(out_tag), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    sb_q.delete(); mq.delete(); rr_m = N - 1; pend = '0; err_exp = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    reset = 1'b1; in_reset = 1'b0;

    // First grant after reset goes to requester 0.
    pend = '1;
    run_cycle();
    chk("post_rst_grant", 64'(grant_cnt > 0 && rr_m == 0), 64'd1);
    rdy_v = 1'b1;
    for (int k = 0; k < 30 && pend != '0; k++) run_cycle();
    drain();

    // Protocol error: the multiplier never signals done for the op at the tail.
    pend = 4'b0001; ptag[0] = T'($urandom); drop_done = 1'b1;
    run_cycle();
    repeat (8) run_cycle();
    chk("proto_err", 64'(err), 64'd1);
    drop_done = 1'b0;
    repeat (3) run_cycle();
    chk("proto_err_sticky", 64'(err), 64'd1);
    chk("proto_no_push", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
